gpio_comm_pulpino_endpoint: RTL and testbench

Pulpino-side endpoint of the 8-bit GPIO word-transfer protocol spoken by `gpio_pulpino_comm` on the FPGA/USB side. Receives 32-bit words arriving as four bytes on the inbound channel and acknowledges each byte with the 2-bit turn code. Serialises 32-bit words from the Pulpino core onto the outbound channel and waits for the 1-bit IO acknowledge. Sits between the Pulpino GPIO pads and a memory-mapped register wrapper; both channels run independently and concurrently.

---
 rtl/gpio_comm_pulpino_endpoint.sv | 224 ++++++++++++++++++++++
 tb/tb_gpio_comm_pulpino_endpoint.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_comm_pulpino_endpoint.sv
// Pulpino-side endpoint of the 8-bit GPIO word-transfer protocol (inbound and outbound channels).
// Define GPIO_COMM_SYNC_EN to put 2-flop synchronizers on both IO turn inputs.
module gpio_comm_pulpino_endpoint (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [7:0]  gpio_data_in,
  input  logic [1:0]  data_in_io_turn,
  output logic [1:0]  data_in_pulpino_turn,
  output logic [31:0] rx_word,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [7:0]  gpio_data_out,
  output logic [1:0]  data_out_pulpino_turn,
  input  logic        data_out_io_turn,
  input  logic [31:0] tx_word,
  input  logic        tx_start,
  output logic        tx_busy,
  output logic        tx_done
);

  function automatic logic [1:0] turnCode(input logic [1:0] k);
    case (k)
      2'd0:    return 2'b01;
      2'd1:    return 2'b00;
      2'd2:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  logic [1:0] w_inTurn;
  logic       w_outAck;

`ifdef GPIO_COMM_SYNC_EN
  logic [1:0] r_inSync0, r_inSync1;
  logic       r_outSync0, r_outSync1;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_inSync0  <= 2'b00;
      r_inSync1  <= 2'b00;
      r_outSync0 <= 1'b0;
      r_outSync1 <= 1'b0;
    end else begin
      r_inSync0  <= data_in_io_turn;
      r_inSync1  <= r_inSync0;
      r_outSync0 <= data_out_io_turn;
      r_outSync1 <= r_outSync0;
    end
  end

  assign w_inTurn = r_inSync1;
  assign w_outAck = r_outSync1;
`else
  assign w_inTurn = data_in_io_turn;
  assign w_outAck = data_out_io_turn;
`endif

  typedef enum logic [2:0] {R_B0, R_B1, R_B2, R_B3, R_FIN} rxState_t;

  rxState_t    r_rxState, w_rxStateNext;
  logic [1:0]  r_rxAck, w_rxAckNext;
  logic [23:0] r_rxBytes, w_rxBytesNext;
  logic [31:0] r_rxWord, w_rxWordNext;
  logic        r_rxValid, w_rxValidNext;
  logic        r_rxErr, w_rxErrNext;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_rxState <= R_B0;
      r_rxAck   <= 2'b00;
      r_rxBytes <= 24'd0;
      r_rxWord  <= 32'd0;
      r_rxValid <= 1'b0;
      r_rxErr   <= 1'b0;
    end else begin
      r_rxState <= w_rxStateNext;
      r_rxAck   <= w_rxAckNext;
      r_rxBytes <= w_rxBytesNext;
      r_rxWord  <= w_rxWordNext;
      r_rxValid <= w_rxValidNext;
      r_rxErr   <= w_rxErrNext;
    end
  end

  // Code 11 aborts from any state; otherwise each state waits for its own code and holds on anything else.
  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxAckNext   = r_rxAck;
    w_rxBytesNext = r_rxBytes;
    w_rxWordNext  = r_rxWord;
    w_rxValidNext = 1'b0;
    w_rxErrNext   = 1'b0;
    if (w_inTurn == 2'b11) begin
      w_rxErrNext   = 1'b1;
      w_rxAckNext   = 2'b00;
      w_rxBytesNext = 24'd0;
      w_rxStateNext = R_B0;
    end else begin
      case (r_rxState)
        R_B0: if (w_inTurn == 2'b01) begin
          w_rxBytesNext[7:0] = gpio_data_in;
          w_rxAckNext        = 2'b01;
          w_rxStateNext      = R_B1;
        end
        R_B1: if (w_inTurn == 2'b00) begin
          w_rxBytesNext[15:8] = gpio_data_in;
          w_rxAckNext         = 2'b00;
          w_rxStateNext       = R_B2;
        end
        R_B2: if (w_inTurn == 2'b01) begin
          w_rxBytesNext[23:16] = gpio_data_in;
          w_rxAckNext          = 2'b01;
          w_rxStateNext        = R_B3;
        end
        R_B3: if (w_inTurn == 2'b10) begin
          w_rxWordNext  = {gpio_data_in, r_rxBytes};
          w_rxValidNext = 1'b1;
          w_rxAckNext   = 2'b10;
          w_rxStateNext = R_FIN;
        end
        R_FIN: if (w_inTurn == 2'b00) begin
          w_rxAckNext   = 2'b00;
          w_rxStateNext = R_B0;
        end
        default: w_rxStateNext = R_B0;
      endcase
    end
  end

  typedef enum logic [3:0] {
    T_IDLE, T_SET0, T_WAIT0, T_SET1, T_WAIT1, T_SET2, T_WAIT2, T_SET3, T_WAIT3, T_FIN
  } txState_t;

  txState_t    r_txState, w_txStateNext;
  logic [31:0] r_txWord, w_txWordNext;
  logic [7:0]  r_txData, w_txDataNext;
  logic [1:0]  r_txTurn, w_txTurnNext;
  logic        r_txBusy, w_txBusyNext;
  logic        r_txDone, w_txDoneNext;
  logic [1:0]  w_txIdx;
  logic [7:0]  w_txByte;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_txState <= T_IDLE;
      r_txWord  <= 32'd0;
      r_txData  <= 8'd0;
      r_txTurn  <= 2'b00;
      r_txBusy  <= 1'b0;
      r_txDone  <= 1'b0;
    end else begin
      r_txState <= w_txStateNext;
      r_txWord  <= w_txWordNext;
      r_txData  <= w_txDataNext;
      r_txTurn  <= w_txTurnNext;
      r_txBusy  <= w_txBusyNext;
      r_txDone  <= w_txDoneNext;
    end
  end

  always_comb begin
    w_txIdx = 2'd0;
    case (r_txState)
      T_SET1, T_WAIT1: w_txIdx = 2'd1;
      T_SET2, T_WAIT2: w_txIdx = 2'd2;
      T_SET3, T_WAIT3: w_txIdx = 2'd3;
      default:         w_txIdx = 2'd0;
    endcase
    case (w_txIdx)
      2'd0:    w_txByte = r_txWord[7:0];
      2'd1:    w_txByte = r_txWord[15:8];
      2'd2:    w_txByte = r_txWord[23:16];
      default: w_txByte = r_txWord[31:24];
    endcase
  end

  // Ack is only honoured once our turn code is on the pins; the expected ack alternates so a stale level never matches.
  always_comb begin
    w_txStateNext = r_txState;
    w_txWordNext  = r_txWord;
    w_txDataNext  = r_txData;
    w_txTurnNext  = r_txTurn;
    w_txBusyNext  = r_txBusy;
    w_txDoneNext  = 1'b0;
    case (r_txState)
      T_IDLE: if (tx_start) begin
        w_txWordNext  = tx_word;
        w_txBusyNext  = 1'b1;
        w_txStateNext = T_SET0;
      end
      T_SET0, T_SET1, T_SET2, T_SET3: begin
        w_txDataNext  = w_txByte;
        w_txStateNext = txState_t'(r_txState + 4'd1);
      end
      T_WAIT0, T_WAIT1, T_WAIT2, T_WAIT3: begin
        w_txTurnNext = turnCode(w_txIdx);
        if (r_txTurn == turnCode(w_txIdx) && w_outAck == ~w_txIdx[0]) begin
          if (w_txIdx == 2'd3) begin
            w_txTurnNext  = 2'b00;
            w_txStateNext = T_FIN;
          end else begin
            w_txStateNext = txState_t'(r_txState + 4'd1);
          end
        end
      end
      T_FIN: begin
        w_txDoneNext  = 1'b1;
        w_txBusyNext  = 1'b0;
        w_txStateNext = T_IDLE;
      end
      default: w_txStateNext = T_IDLE;
    endcase
  end

  assign data_in_pulpino_turn  = r_rxAck;
  assign rx_word               = r_rxWord;
  assign rx_valid              = r_rxValid;
  assign rx_err                = r_rxErr;
  assign gpio_data_out         = r_txData;
  assign data_out_pulpino_turn = r_txTurn;
  assign tx_busy               = r_txBusy;
  assign tx_done               = r_txDone;

endmodule

// File: tb/tb_gpio_comm_pulpino_endpoint.sv
// Self-checking bench for gpio_comm_pulpino_endpoint: IO-side protocol models drive both channels
// with random words and delays; expectations come from the protocol rules (byte order, turn codes, latencies).
module tb_gpio_comm_pulpino_endpoint;

`ifdef GPIO_COMM_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int BUDGET = 60;
  localparam logic [1:0] CODES [4] = '{2'b01, 2'b00, 2'b01, 2'b10};

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  gpio_data_in;
  logic [1:0]  data_in_io_turn;
  logic [1:0]  data_in_pulpino_turn;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic        rx_err;
  logic [7:0]  gpio_data_out;
  logic [1:0]  data_out_pulpino_turn;
  logic        data_out_io_turn;
  logic [31:0] tx_word;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;

  int nChecks = 0;
  int nFails  = 0;
  int rxValidCount = 0;
  int rxErrCount   = 0;
  int txDoneCount  = 0;
  logic [31:0] expRxWord;

  gpio_comm_pulpino_endpoint dut (
    .clk                  (clk),
    .reset_i              (reset_i),
    .gpio_data_in         (gpio_data_in),
    .data_in_io_turn      (data_in_io_turn),
    .data_in_pulpino_turn (data_in_pulpino_turn),
    .rx_word              (rx_word),
    .rx_valid             (rx_valid),
    .rx_err               (rx_err),
    .gpio_data_out        (gpio_data_out),
    .data_out_pulpino_turn(data_out_pulpino_turn),
    .data_out_io_turn     (data_out_io_turn),
    .tx_word              (tx_word),
    .tx_start             (tx_start),
    .tx_busy              (tx_busy),
    .tx_done              (tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxValidCount = rxValidCount + 1;
    if (rx_err === 1'b1)   rxErrCount   = rxErrCount + 1;
    if (tx_done === 1'b1)  txDoneCount  = txDoneCount + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IO-side sender: present byte k with code k, wait for the mirrored ack; 4 bytes also closes with idle 00.
  task automatic ioSendWord(input logic [31:0] word, input int nBytes, output int timeouts,
                            output int badLat, output logic validAtLast, output logic [31:0] wordAtLast);
    int n;
    timeouts = 0; badLat = 0; validAtLast = 1'b0; wordAtLast = 32'd0;
    for (int k = 0; k < nBytes; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      gpio_data_in    = word[8*k +: 8];
      data_in_io_turn = CODES[k];
      tick(); n = 1;
      while (data_in_pulpino_turn !== CODES[k] && n < BUDGET) begin tick(); n++; end
      if (data_in_pulpino_turn !== CODES[k]) timeouts++;
      else if (n != SYNC + 1) badLat++;
      if (k == 3) begin validAtLast = rx_valid; wordAtLast = rx_word; end
    end
    if (nBytes == 4) begin
      data_in_io_turn = 2'b00;
      tick(); n = 1;
      while (data_in_pulpino_turn !== 2'b00 && n < BUDGET) begin tick(); n++; end
      if (data_in_pulpino_turn !== 2'b00) timeouts++;
      else if (n != SYNC + 1) badLat++;
    end
  endtask

  task automatic startTx(output logic busyAfter);
    tx_start = 1'b1;
    tick();
    tx_start  = 1'b0;
    busyAfter = tx_busy;
  endtask

  // IO-side receiver: wait for each turn code, take the byte, answer 1/0/1/0; stops unacked at byte nBytes-1 if nBytes<4.
  task automatic ioRecvWord(input int nBytes, output logic [31:0] got, output int timeouts,
                            output int unstable, output int startLat, output logic doneSeen,
                            output logic [1:0] turnAtDone, output logic busyAtDone);
    int n;
    logic [7:0] prev;
    got = 32'd0; timeouts = 0; unstable = 0; startLat = -1;
    doneSeen = 1'b0; turnAtDone = 2'bxx; busyAtDone = 1'bx;
    for (int k = 0; k < nBytes; k++) begin
      prev = gpio_data_out;
      n = 0;
      while (data_out_pulpino_turn !== CODES[k] && n < BUDGET) begin
        prev = gpio_data_out; tick(); n++;
      end
      if (data_out_pulpino_turn !== CODES[k]) timeouts++;
      if (k == 0) startLat = n;
      got[8*k +: 8] = gpio_data_out;
      if (prev !== gpio_data_out) unstable++;
      if (nBytes == 4 || k < nBytes - 1) begin
        repeat ($urandom_range(0, 2)) tick();
        data_out_io_turn = (k % 2 == 0);
      end
    end
    if (nBytes == 4) begin
      n = 0;
      while (tx_done !== 1'b1 && n < BUDGET) begin tick(); n++; end
      doneSeen = tx_done; turnAtDone = data_out_pulpino_turn; busyAtDone = tx_busy;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; gpio_data_in = 8'd0; data_in_io_turn = 2'b00;
    data_out_io_turn = 1'b0; tx_word = 32'd0; tx_start = 1'b0;
    repeat (3) tick();
    nChecks++; if (data_in_pulpino_turn !== 2'b00) begin nFails++; $display("[TB] FAIL reset_in_ack: got %b expected 00", data_in_pulpino_turn); end
    nChecks++; if (rx_word !== 32'd0) begin nFails++; $display("[TB] FAIL reset_rx_word: got %h expected 0", rx_word); end
    nChecks++; if (rx_valid !== 1'b0 || rx_err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rx_pulses: got valid=%b err=%b expected 0 0", rx_valid, rx_err); end
    nChecks++; if (gpio_data_out !== 8'd0) begin nFails++; $display("[TB] FAIL reset_data_out: got %h expected 0", gpio_data_out); end
    nChecks++; if (data_out_pulpino_turn !== 2'b00) begin nFails++; $display("[TB] FAIL reset_out_turn: got %b expected 00", data_out_pulpino_turn); end
    nChecks++; if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_tx_flags: got busy=%b done=%b expected 0 0", tx_busy, tx_done); end
    reset_i = 1'b0;
    tick();
    expRxWord = 32'd0;
  endtask

  task automatic test_inbound();
    logic [31:0] w, wordAtLast;
    logic validAtLast;
    int timeouts, badLat, base;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 32'h1234ABCD : $urandom;
      base = rxValidCount;
      ioSendWord(w, 4, timeouts, badLat, validAtLast, wordAtLast);
      repeat (2) tick();
      expRxWord = w;
      nChecks++; if (timeouts != 0) begin nFails++; $display("[TB] FAIL in_timeout: got %0d expected 0", timeouts); end
      nChecks++; if (badLat != 0) begin nFails++; $display("[TB] FAIL in_ack_latency: got %0d wrong expected 0 (latency %0d)", badLat, SYNC + 1); end
      nChecks++; if (validAtLast !== 1'b1) begin nFails++; $display("[TB] FAIL in_valid_with_ack10: got %b expected 1", validAtLast); end
      nChecks++; if (wordAtLast !== w) begin nFails++; $display("[TB] FAIL in_word: got %h expected %h", wordAtLast, w); end
      nChecks++; if (rxValidCount - base != 1) begin nFails++; $display("[TB] FAIL in_valid_count: got %0d expected 1", rxValidCount - base); end
      nChecks++; if (data_in_pulpino_turn !== 2'b00 || rx_word !== expRxWord) begin nFails++; $display("[TB] FAIL in_idle: got ack=%b word=%h expected 00 %h", data_in_pulpino_turn, rx_word, expRxWord); end
    end
  endtask

  task automatic test_outbound();
    logic [31:0] w, got;
    logic busyAfter, doneSeen, busyAtDone;
    logic [1:0] turnAtDone;
    int timeouts, unstable, startLat, base;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 32'hDEADBEEF : $urandom;
      base = txDoneCount;
      tx_word = w;
      startTx(busyAfter);
      tx_word = ~w;
      ioRecvWord(4, got, timeouts, unstable, startLat, doneSeen, turnAtDone, busyAtDone);
      repeat (2) tick();
      nChecks++; if (busyAfter !== 1'b1) begin nFails++; $display("[TB] FAIL out_busy_on_start: got %b expected 1", busyAfter); end
      nChecks++; if (timeouts != 0) begin nFails++; $display("[TB] FAIL out_timeout: got %0d expected 0", timeouts); end
      nChecks++; if (startLat != 2) begin nFails++; $display("[TB] FAIL out_start_latency: got %0d expected 2", startLat); end
      nChecks++; if (unstable != 0) begin nFails++; $display("[TB] FAIL out_data_setup: got %0d unstable bytes expected 0", unstable); end
      nChecks++; if (got !== w) begin nFails++; $display("[TB] FAIL out_word: got %h expected %h", got, w); end
      nChecks++; if (doneSeen !== 1'b1 || turnAtDone !== 2'b00 || busyAtDone !== 1'b0) begin nFails++; $display("[TB] FAIL out_done: got done=%b turn=%b busy=%b expected 1 00 0", doneSeen, turnAtDone, busyAtDone); end
      nChecks++; if (txDoneCount - base != 1) begin nFails++; $display("[TB] FAIL out_done_count: got %0d expected 1", txDoneCount - base); end
      nChecks++; if (gpio_data_out !== w[31:24]) begin nFails++; $display("[TB] FAIL out_hold_byte3: got %h expected %h", gpio_data_out, w[31:24]); end
    end
  endtask

  task automatic test_concurrent(input logic [31:0] inWord, input logic [31:0] outWord, input string tag);
    logic [31:0] wordAtLast, got;
    logic validAtLast, busyAfter, doneSeen, busyAtDone;
    logic [1:0] turnAtDone;
    int inTo, badLat, outTo, unstable, startLat;
    tx_word = outWord;
    fork
      ioSendWord(inWord, 4, inTo, badLat, validAtLast, wordAtLast);
      begin
        startTx(busyAfter);
        ioRecvWord(4, got, outTo, unstable, startLat, doneSeen, turnAtDone, busyAtDone);
      end
    join
    repeat (2) tick();
    expRxWord = inWord;
    nChecks++; if (inTo != 0 || outTo != 0 || badLat != 0) begin nFails++; $display("[TB] FAIL %s_protocol: got in_to=%0d out_to=%0d bad_lat=%0d expected 0 0 0", tag, inTo, outTo, badLat); end
    nChecks++; if (wordAtLast !== inWord || rx_word !== inWord || validAtLast !== 1'b1) begin nFails++; $display("[TB] FAIL %s_in_word: got %h valid=%b expected %h valid=1", tag, wordAtLast, validAtLast, inWord); end
    nChecks++; if (got !== outWord || doneSeen !== 1'b1) begin nFails++; $display("[TB] FAIL %s_out_word: got %h done=%b expected %h done=1", tag, got, doneSeen, outWord); end
  endtask

  task automatic test_rx_error();
    logic [31:0] wordAtLast;
    logic validAtLast;
    int timeouts, badLat, vBase, eBase;
    vBase = rxValidCount; eBase = rxErrCount;
    ioSendWord($urandom, 2, timeouts, badLat, validAtLast, wordAtLast);
    data_in_io_turn = 2'b11; tick(); data_in_io_turn = 2'b00;
    repeat (SYNC + 3) tick();
    nChecks++; if (rxErrCount - eBase != 1) begin nFails++; $display("[TB] FAIL err_after_b1_pulse: got %0d expected 1", rxErrCount - eBase); end
    nChecks++; if (data_in_pulpino_turn !== 2'b00 || rx_word !== expRxWord) begin nFails++; $display("[TB] FAIL err_after_b1_state: got ack=%b word=%h expected 00 %h", data_in_pulpino_turn, rx_word, expRxWord); end
    ioSendWord($urandom, 3, timeouts, badLat, validAtLast, wordAtLast);
    nChecks++; if (data_in_pulpino_turn !== 2'b01) begin nFails++; $display("[TB] FAIL err_pre_b2_ack: got %b expected 01", data_in_pulpino_turn); end
    data_in_io_turn = 2'b11; tick(); data_in_io_turn = 2'b00;
    repeat (SYNC + 3) tick();
    nChecks++; if (rxErrCount - eBase != 2 || data_in_pulpino_turn !== 2'b00) begin nFails++; $display("[TB] FAIL err_after_b2: got errs=%0d ack=%b expected 2 00", rxErrCount - eBase, data_in_pulpino_turn); end
    nChecks++; if (rxValidCount - vBase != 0 || rx_word !== expRxWord) begin nFails++; $display("[TB] FAIL err_no_word: got valids=%0d word=%h expected 0 %h", rxValidCount - vBase, rx_word, expRxWord); end
    ioSendWord(32'h00000001, 4, timeouts, badLat, validAtLast, wordAtLast);
    repeat (2) tick();
    expRxWord = 32'h00000001;
    nChecks++; if (timeouts != 0 || wordAtLast !== 32'h1 || rx_word !== 32'h1) begin nFails++; $display("[TB] FAIL err_recover_word: got %h timeouts=%0d expected 00000001 0", wordAtLast, timeouts); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, got;
    logic busyAfter, doneSeen, busyAtDone;
    logic [1:0] turnAtDone;
    int timeouts, unstable, startLat, base;
    a = $urandom;
    base = txDoneCount;
    tx_word = a;
    startTx(busyAfter);
    tx_word = ~a; tx_start = 1'b1; tick(); tx_start = 1'b0;
    ioRecvWord(4, got, timeouts, unstable, startLat, doneSeen, turnAtDone, busyAtDone);
    repeat (6) tick();
    nChecks++; if (got !== a || timeouts != 0) begin nFails++; $display("[TB] FAIL busy_start_word: got %h expected %h", got, a); end
    nChecks++; if (txDoneCount - base != 1 || tx_busy !== 1'b0 || data_out_pulpino_turn !== 2'b00) begin nFails++; $display("[TB] FAIL busy_start_ignored: got done=%0d busy=%b turn=%b expected 1 0 00", txDoneCount - base, tx_busy, data_out_pulpino_turn); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] wordAtLast, got;
    logic validAtLast, busyAfter, doneSeen, busyAtDone;
    logic [1:0] turnAtDone;
    int timeouts, badLat, unstable, startLat, vBase, dBase;
    ioSendWord($urandom, 2, timeouts, badLat, validAtLast, wordAtLast);
    tx_word = $urandom;
    startTx(busyAfter);
    ioRecvWord(3, got, timeouts, unstable, startLat, doneSeen, turnAtDone, busyAtDone);
    nChecks++; if (timeouts != 0 || data_out_pulpino_turn !== 2'b01 || tx_busy !== 1'b1) begin nFails++; $display("[TB] FAIL rst_reach_b2: got turn=%b busy=%b expected 01 1", data_out_pulpino_turn, tx_busy); end
    vBase = rxValidCount; dBase = txDoneCount;
    reset_i = 1'b1; data_in_io_turn = 2'b00; data_out_io_turn = 1'b0; gpio_data_in = 8'd0;
    tick();
    expRxWord = 32'd0;
    nChecks++; if ({data_in_pulpino_turn, rx_word, rx_valid, rx_err, gpio_data_out, data_out_pulpino_turn, tx_busy, tx_done} !== 48'd0) begin nFails++; $display("[TB] FAIL rst_outputs: got ack=%b word=%h v=%b e=%b d=%h t=%b busy=%b done=%b expected all 0", data_in_pulpino_turn, rx_word, rx_valid, rx_err, gpio_data_out, data_out_pulpino_turn, tx_busy, tx_done); end
    reset_i = 1'b0;
    repeat (5) tick();
    nChecks++; if (rxValidCount - vBase != 0 || txDoneCount - dBase != 0) begin nFails++; $display("[TB] FAIL rst_no_pulses: got valids=%0d dones=%0d expected 0 0", rxValidCount - vBase, txDoneCount - dBase); end
    test_concurrent($urandom, $urandom, "rst_fresh");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start, synchronizer depth %0d", SYNC);
    test_reset();
    test_inbound();
    test_outbound();
    test_concurrent(32'hA5A50F0F, 32'h01020304, "concurrent");
    test_rx_error();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
